// File: rtl/cpu_control_unit.sv
// cpu_control_unit: hardwired Moore control sequencer for the 32-bit datapath.
// Fetches an instruction in T0-T2, latches its opcode, then steps the execute
// T-states one per clock. Every datapath strobe is a decode of the current
// state and the latched opcode. The one exception is PCin in the branch T6
// state, which also follows ConFFQ.
//
// The IR input must already hold the fetched instruction while the sequencer
// is in T2. nop and halt are resolved in that cycle, and the opcode register
// samples IR on the T2->T3 edge.
module cpu_control_unit #(
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned OPC_LSB      = 27
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        ConFFQ,
    input  logic        run,
    output logic        dp_clear,
    output logic        PCin,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MDMuxread,
    output logic        IRin,
    output logic        Yin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CSEout,
    output logic        RAMread,
    output logic        RAMwrite,
    output logic        InPortout,
    output logic        OutPortin,
    output logic        CONin,
    output logic        running,
    output logic        halted,
    output logic        illegal
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_IDLE = 4'd1;
    localparam logic [3:0] S_T0   = 4'd2;
    localparam logic [3:0] S_T1   = 4'd3;
    localparam logic [3:0] S_T2   = 4'd4;
    localparam logic [3:0] S_T3   = 4'd5;
    localparam logic [3:0] S_T4   = 4'd6;
    localparam logic [3:0] S_T5   = 4'd7;
    localparam logic [3:0] S_T6   = 4'd8;
    localparam logic [3:0] S_T7   = 4'd9;
    localparam logic [3:0] S_HALT = 4'd10;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [3:0] RST_LAST = 4'(RESET_CYCLES - 1);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [3:0] rst_cnt;
    logic [4:0] opc;
    logic [4:0] ir_opc;
    logic [3:0] last_st;
    logic [3:0] boundary_st;
    logic       op_alu;
    logic       op_imm;
    logic       op_mem;
    logic       op_muldiv;
    logic       op_negnot;
    logic       op_io;
    logic       op_legal;

    // Only the opcode field matters here; the rest of IR belongs to the datapath.
    logic unused_ir;
    assign unused_ir = ^IR;

    assign ir_opc = IR[OPC_LSB +: 5];

    // Classify the latched opcode into instruction families.
    always_comb begin
        op_alu    = opc inside {[OP_ADD:OP_SHL]};
        op_imm    = opc inside {OP_ADDI, OP_ANDI, OP_ORI};
        op_mem    = opc inside {OP_LD, OP_LDI, OP_ST};
        op_muldiv = opc inside {OP_MUL, OP_DIV};
        op_negnot = opc inside {OP_NEG, OP_NOT};
        op_io     = opc inside {OP_IN, OP_OUT, OP_MFHI, OP_MFLO};
        op_legal  = op_alu | op_imm | op_mem | op_muldiv | op_negnot | op_io
                  | (opc == OP_BR);
    end

    // Last execute state of the latched instruction, i.e. its instruction boundary.
    always_comb begin
        last_st = S_T3;
        if (op_alu || op_imm || opc == OP_LDI) begin
            last_st = S_T5;
        end else if (opc == OP_LD || opc == OP_ST) begin
            last_st = S_T7;
        end else if (op_muldiv || opc == OP_BR) begin
            last_st = S_T6;
        end else if (op_negnot) begin
            last_st = S_T4;
        end
    end

    assign boundary_st = run ? S_T0 : S_IDLE;

    // Next-state sequencing: reset hold, idle, fetch, execute and halt.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:  if (rst_cnt == RST_LAST) state_nxt = S_IDLE;
            S_IDLE: if (run) state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1:   state_nxt = S_T2;
            S_T2: begin
                if (ir_opc == OP_HALT)     state_nxt = S_HALT;
                else if (ir_opc == OP_NOP) state_nxt = boundary_st;
                else                       state_nxt = S_T3;
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state == last_st) state_nxt = boundary_st;
                else                  state_nxt = state + 4'd1;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    // State, reset-hold counter and latched opcode registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= S_RST;
            rst_cnt <= 4'd0;
            opc     <= 5'd0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= (state == S_RST) ? rst_cnt + 4'd1 : 4'd0;
            if (state == S_T2) opc <= ir_opc;
        end
    end

    // Moore output decode of state and latched opcode.
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        {PCin, PCout, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin} = '0;
        {Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin, HIout, LOout} = '0;
        {ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, CSEout} = '0;
        {RAMread, RAMwrite, InPortout, OutPortin, CONin} = '0;
        dp_clear = (state == S_RST);
        running  = (state >= S_T0) && (state <= S_T7);
        halted   = (state == S_HALT);
        illegal  = 1'b0;
        case (state)
            S_T0: {PCout, MARin, IncPC, Zlowin} = '1;
            S_T1: {Zlowout, PCin, MDMuxread, RAMread, MDRin} = '1;
            S_T2: {MDRout, IRin} = '1;
            S_T3: begin
                if (op_alu || op_imm) begin
                    {Grb, Rout, Yin} = '1;
                end else if (op_mem) begin
                    {Grb, BAout, Yin} = '1;
                end else if (op_muldiv) begin
                    {Gra, Rout, Yin} = '1;
                end else if (op_negnot) begin
                    {Grb, Rout, Zlowin} = '1;
                    NEG = (opc == OP_NEG);
                    NOT = (opc == OP_NOT);
                end else if (opc == OP_BR) begin
                    {Gra, Rout, CONin} = '1;
                end else if (opc == OP_IN) begin
                    {Gra, Rin, InPortout} = '1;
                end else if (opc == OP_OUT) begin
                    {Gra, Rout, OutPortin} = '1;
                end else if (opc == OP_MFHI || opc == OP_MFLO) begin
                    {Gra, Rin} = '1;
                    HIout = (opc == OP_MFHI);
                    LOout = (opc == OP_MFLO);
                end
                illegal = !op_legal;
            end
            S_T4: begin
                if (op_alu) begin
                    {Grc, Rout, Zlowin} = '1;
                    ADD  = (opc == OP_ADD);
                    SUB  = (opc == OP_SUB);
                    AND  = (opc == OP_AND);
                    OR   = (opc == OP_OR);
                    ROR  = (opc == OP_ROR);
                    ROL  = (opc == OP_ROL);
                    SHR  = (opc == OP_SHR);
                    SHRA = (opc == OP_SHRA);
                    SHL  = (opc == OP_SHL);
                end else if (op_imm) begin
                    {CSEout, Zlowin} = '1;
                    ADD = (opc == OP_ADDI);
                    AND = (opc == OP_ANDI);
                    OR  = (opc == OP_ORI);
                end else if (op_mem) begin
                    {CSEout, ADD, Zlowin} = '1;
                end else if (op_muldiv) begin
                    {Grb, Rout, Zhighin, Zlowin} = '1;
                    MUL = (opc == OP_MUL);
                    DIV = (opc == OP_DIV);
                end else if (op_negnot) begin
                    {Zlowout, Gra, Rin} = '1;
                end else if (opc == OP_BR) begin
                    {PCout, Yin} = '1;
                end
            end
            S_T5: begin
                if (op_alu || op_imm || opc == OP_LDI) begin
                    {Zlowout, Gra, Rin} = '1;
                end else if (opc == OP_LD || opc == OP_ST) begin
                    {Zlowout, MARin} = '1;
                end else if (op_muldiv) begin
                    {Zlowout, LOin} = '1;
                end else if (opc == OP_BR) begin
                    {CSEout, ADD, Zlowin} = '1;
                end
            end
            S_T6: begin
                if (opc == OP_LD) begin
                    {MDMuxread, RAMread, MDRin} = '1;
                end else if (opc == OP_ST) begin
                    {Gra, Rout, MDRin} = '1;
                end else if (op_muldiv) begin
                    {Zhighout, HIin} = '1;
                end else if (opc == OP_BR) begin
                    Zlowout = 1'b1;
                    PCin    = ConFFQ;
                end
            end
            S_T7: begin
                if (opc == OP_LD) begin
                    {MDRout, Gra, Rin} = '1;
                end else if (opc == OP_ST) begin
                    RAMwrite = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit. A behavioural model lists, per
// instruction, the exact set of strobes expected on every clock, and the
// observed output vector is compared against it cycle by cycle.
module tb_cpu_control_unit;

    localparam int RC = 3;

    logic        clock, clear, ConFFQ, run;
    logic [31:0] IR;
    logic dp_clear, PCin, PCout, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin;
    logic Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin, HIout, LOout;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CSEout;
    logic RAMread, RAMwrite, InPortout, OutPortin, CONin, running, halted, illegal;

    cpu_control_unit #(.RESET_CYCLES(RC), .OPC_LSB(27)) dut (
        .clock(clock), .clear(clear), .IR(IR), .ConFFQ(ConFFQ), .run(run),
        .dp_clear(dp_clear), .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .MDMuxread(MDMuxread), .IRin(IRin), .Yin(Yin),
        .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR), .SHR(SHR),
        .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .CSEout(CSEout), .RAMread(RAMread), .RAMwrite(RAMwrite), .InPortout(InPortout),
        .OutPortin(OutPortin), .CONin(CONin), .running(running), .halted(halted),
        .illegal(illegal)
    );

    logic [45:0] obs;
    assign obs = {dp_clear, PCin, PCout, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin,
                  Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin, HIout, LOout,
                  ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
                  Gra, Grb, Grc, Rin, Rout, BAout, CSEout,
                  RAMread, RAMwrite, InPortout, OutPortin, CONin, running, halted, illegal};

    localparam logic [45:0] B = 46'd1;
    localparam logic [45:0] M_DPC = B << 45, M_PCin = B << 44, M_PCout = B << 43;
    localparam logic [45:0] M_IncPC = B << 42, M_MARin = B << 41, M_MDRin = B << 40;
    localparam logic [45:0] M_MDRout = B << 39, M_MDMux = B << 38, M_IRin = B << 37;
    localparam logic [45:0] M_Yin = B << 36, M_Zhin = B << 35, M_Zlin = B << 34;
    localparam logic [45:0] M_Zhout = B << 33, M_Zlout = B << 32, M_HIin = B << 31;
    localparam logic [45:0] M_LOin = B << 30, M_HIout = B << 29, M_LOout = B << 28;
    localparam logic [45:0] M_ADD = B << 27, M_SUB = B << 26, M_MUL = B << 25, M_DIV = B << 24;
    localparam logic [45:0] M_AND = B << 23, M_OR = B << 22, M_SHR = B << 21, M_SHRA = B << 20;
    localparam logic [45:0] M_SHL = B << 19, M_ROR = B << 18, M_ROL = B << 17;
    localparam logic [45:0] M_NEG = B << 16, M_NOT = B << 15;
    localparam logic [45:0] M_Gra = B << 14, M_Grb = B << 13, M_Grc = B << 12;
    localparam logic [45:0] M_Rin = B << 11, M_Rout = B << 10, M_BAout = B << 9;
    localparam logic [45:0] M_CSE = B << 8, M_RAMrd = B << 7, M_RAMwr = B << 6;
    localparam logic [45:0] M_InP = B << 5, M_OutP = B << 4, M_CON = B << 3;
    localparam logic [45:0] M_RUN = B << 2, M_HLT = B << 1, M_ILL = B << 0;

    int checks = 0;
    int errors = 0;
    logic [45:0] exp_q[$];
    logic [45:0] obs_q[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ALU operation strobe for each three-register opcode, by mnemonic order.
    function automatic logic [45:0] alu_mask(input logic [4:0] op);
        logic [45:0] tab [0:8];
        tab = '{M_ADD, M_SUB, M_AND, M_OR, M_ROR, M_ROL, M_SHR, M_SHRA, M_SHL};
        return tab[op - 5'd3];
    endfunction

    // Reference model: append the expected strobe set of every clock of one instruction.
    task automatic push_expected(input logic [4:0] op, input logic cff);
        logic [45:0] r;
        r = M_RUN;
        exp_q.push_back(r | M_PCout | M_MARin | M_IncPC | M_Zlin);
        exp_q.push_back(r | M_Zlout | M_PCin | M_MDMux | M_RAMrd | M_MDRin);
        exp_q.push_back(r | M_MDRout | M_IRin);
        if (op >= 5'd3 && op <= 5'd11) begin
            exp_q.push_back(r | M_Grb | M_Rout | M_Yin);
            exp_q.push_back(r | M_Grc | M_Rout | alu_mask(op) | M_Zlin);
            exp_q.push_back(r | M_Zlout | M_Gra | M_Rin);
        end else if (op >= 5'd12 && op <= 5'd14) begin
            exp_q.push_back(r | M_Grb | M_Rout | M_Yin);
            exp_q.push_back(r | M_CSE | (op == 5'd12 ? M_ADD : op == 5'd13 ? M_AND : M_OR) | M_Zlin);
            exp_q.push_back(r | M_Zlout | M_Gra | M_Rin);
        end else if (op <= 5'd2) begin
            exp_q.push_back(r | M_Grb | M_BAout | M_Yin);
            exp_q.push_back(r | M_CSE | M_ADD | M_Zlin);
            if (op == 5'd1) begin
                exp_q.push_back(r | M_Zlout | M_Gra | M_Rin);
            end else begin
                exp_q.push_back(r | M_Zlout | M_MARin);
                if (op == 5'd0) begin
                    exp_q.push_back(r | M_MDMux | M_RAMrd | M_MDRin);
                    exp_q.push_back(r | M_MDRout | M_Gra | M_Rin);
                end else begin
                    exp_q.push_back(r | M_Gra | M_Rout | M_MDRin);
                    exp_q.push_back(r | M_RAMwr);
                end
            end
        end else if (op == 5'd15 || op == 5'd16) begin
            exp_q.push_back(r | M_Gra | M_Rout | M_Yin);
            exp_q.push_back(r | M_Grb | M_Rout | (op == 5'd15 ? M_MUL : M_DIV) | M_Zhin | M_Zlin);
            exp_q.push_back(r | M_Zlout | M_LOin);
            exp_q.push_back(r | M_Zhout | M_HIin);
        end else if (op == 5'd17 || op == 5'd18) begin
            exp_q.push_back(r | M_Grb | M_Rout | (op == 5'd17 ? M_NEG : M_NOT) | M_Zlin);
            exp_q.push_back(r | M_Zlout | M_Gra | M_Rin);
        end else if (op == 5'd19) begin
            exp_q.push_back(r | M_Gra | M_Rout | M_CON);
            exp_q.push_back(r | M_PCout | M_Yin);
            exp_q.push_back(r | M_CSE | M_ADD | M_Zlin);
            exp_q.push_back(r | M_Zlout | (cff ? M_PCin : 46'd0));
        end else if (op == 5'd22) exp_q.push_back(r | M_Gra | M_Rin | M_InP);
        else if (op == 5'd23) exp_q.push_back(r | M_Gra | M_Rout | M_OutP);
        else if (op == 5'd24) exp_q.push_back(r | M_Gra | M_Rin | M_HIout);
        else if (op == 5'd25) exp_q.push_back(r | M_Gra | M_Rin | M_LOout);
        else if (op != 5'd26 && op != 5'd27) exp_q.push_back(r | M_ILL);
    endtask

    // Drive one instruction from its T0 cycle, recording outputs each cycle.
    // run takes run_val at cycle ridx (or the last cycle if ridx is out of range).
    task automatic run_instr(input logic [31:0] ir, input logic cff, input int ridx,
                             input logic run_val);
        int n0, len, at;
        n0 = exp_q.size();
        push_expected(ir[31:27], cff);
        len = exp_q.size() - n0;
        at = (ridx < 0 || ridx >= len) ? len - 1 : ridx;
        for (int i = 0; i < len; i++) begin
            obs_q.push_back(obs);
            if (i == 0) begin IR = ir; ConFFQ = cff; end
            if (i == 3) IR = $urandom();
            if (i == at) run = run_val;
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear = 1'b0; run = 1'b0;
        repeat (3) @(negedge clock);
        clear = 1'b1;
        repeat (RC) @(negedge clock);
    endtask

    task automatic test_reset();
        int n;
        #1;
        checks++;
        if (obs !== M_DPC) begin
            errors++; $display("FAIL reset_async got %h want %h", obs, M_DPC);
        end
        repeat (3) @(negedge clock);
        clear = 1'b1;
        n = 0;
        while (dp_clear === 1'b1 && n < 40) begin
            @(posedge clock); #1; n++;
        end
        checks++;
        if (n !== RC) begin
            errors++; $display("FAIL reset_hold_cycles got %0d want %0d", n, RC);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== 46'd0) begin
                errors++; $display("FAIL idle_outputs cyc%0d got %h want 0", i, obs);
            end
        end
    endtask

    task automatic test_immediate();
        run = 1'b1;
        @(negedge clock);
        run_instr(32'h0A00FF00, 1'b0, -1, 1'b1);
        run_instr(32'h71A00053, 1'b0, -1, 1'b0);
        obs_q.push_back(obs); exp_q.push_back(46'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL immediate cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_load_store();
        run = 1'b1;
        @(negedge clock);
        run_instr({5'd0, 4'd1, 4'd0, 19'h75}, 1'b0, -1, 1'b1);
        run_instr({5'd2, 4'd1, 4'd1, 19'h90}, 1'b0, -1, 1'b0);
        obs_q.push_back(obs); exp_q.push_back(46'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL load_store cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_branch();
        run = 1'b1;
        @(negedge clock);
        run_instr({5'd19, 4'd5, 4'd0, 19'h10}, 1'b1, -1, 1'b1);
        run_instr({5'd19, 4'd5, 4'd0, 19'h20}, 1'b0, -1, 1'b1);
        run_instr({5'd26, 27'd0}, 1'b0, -1, 1'b0);
        obs_q.push_back(obs); exp_q.push_back(46'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL branch cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_run_stop();
        run = 1'b1;
        @(negedge clock);
        run_instr({5'd3, 4'd2, 4'd3, 4'd4, 15'd0}, 1'b0, 4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            obs_q.push_back(obs); exp_q.push_back(46'd0);
            @(negedge clock);
        end
        run = 1'b1;
        @(negedge clock);
        run_instr({5'd4, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0, 1, 1'b0);
        obs_q.push_back(obs); exp_q.push_back(46'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL run_stop cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_illegal();
        run = 1'b1;
        @(negedge clock);
        run_instr({5'd31, 27'h1234}, 1'b0, -1, 1'b1);
        run_instr({5'd22, 4'd7, 23'd0}, 1'b0, -1, 1'b0);
        obs_q.push_back(obs); exp_q.push_back(46'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL illegal cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        logic [4:0] op;
        logic       rv;
        run = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 60; k++) begin
            do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
            rv = ($urandom_range(0, 3) != 0);
            run_instr({op, 27'($urandom())}, 1'($urandom()), $urandom_range(0, 8), rv);
            if (!rv) begin
                obs_q.push_back(obs); exp_q.push_back(46'd0);
                run = 1'b1;
                @(negedge clock);
            end
        end
        run_instr({5'd26, 27'd0}, 1'b0, -1, 1'b0);
        obs_q.push_back(obs); exp_q.push_back(46'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL random cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_halt();
        run = 1'b1;
        @(negedge clock);
        run_instr({5'd27, 27'd0}, 1'b0, -1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            obs_q.push_back(obs); exp_q.push_back(M_HLT);
            run = 1'($urandom());
            IR = $urandom();
            @(negedge clock);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL halt cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_async_reset();
        logic [31:0] ir;
        do_reset();
        checks++;
        if (obs !== 46'd0) begin
            errors++; $display("FAIL halt_exit_by_reset got %h want 0", obs);
        end
        ir = {5'd15, 4'd6, 4'd7, 19'd0};
        push_expected(ir[31:27], 1'b0);
        run = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 7; i++) begin
            obs_q.push_back(obs);
            if (i == 0) IR = ir;
            if (i == 3) IR = $urandom();
            if (i < 6) @(negedge clock);
        end
        clear = 1'b0;
        #1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL mul_pre_abort cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs !== M_DPC) begin
            errors++; $display("FAIL async_abort got %h want %h", obs, M_DPC);
        end
        exp_q.delete(); obs_q.delete();
        run = 1'b0;
        repeat (2) @(negedge clock);
        clear = 1'b1;
        repeat (RC) @(negedge clock);
        checks++;
        if (obs !== 46'd0) begin
            errors++; $display("FAIL post_abort_idle got %h want 0", obs);
        end
    endtask

    initial begin
        clear = 1'b0; run = 1'b0; IR = 32'd0; ConFFQ = 1'b0;
        test_reset();
        test_immediate();
        test_load_store();
        test_branch();
        test_run_stop();
        test_illegal();
        test_random();
        test_halt();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
